// File: rtl/debounce_pulse_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pulse_pkg;

  localparam int unsigned GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_pulse_sync2.sv
// Two-flop synchroniser for asynchronous board-level inputs.
module debounce_pulse_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_pulse.sv
// Synchronises and debounces a raw button level; one add pulse per accepted
// press, plus the debounced level and a saturating count of aborted edges.
module debounce_pulse
  import debounce_pulse_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                button_in,
  output logic                add,
  output logic                level_out,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam bit                   SINGLE   = (STABLE_CYCLES == 1);

  logic                 sync_in;
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 level_nxt;
  logic                 add_nxt;
  logic                 glitch_inc;
  logic [GLITCH_W-1:0]  glitch_nxt;

  debounce_pulse_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (button_in),
    .q     (sync_in)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE_LOW;
      cnt          <= '0;
      level_out    <= 1'b0;
      add          <= 1'b0;
      glitch_count <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      level_out    <= level_nxt;
      add          <= add_nxt;
      glitch_count <= glitch_nxt;
    end
  end

  // The edge that leaves an IDLE state already counts as the first stable sample.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    level_nxt  = level_out;
    add_nxt    = 1'b0;
    glitch_inc = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (sync_in) begin
          if (SINGLE) begin
            state_nxt = IDLE_HIGH;
            level_nxt = 1'b1;
            add_nxt   = 1'b1;
          end else begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!sync_in) begin
          state_nxt  = IDLE_LOW;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          level_nxt = 1'b1;
          add_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_in) begin
          if (SINGLE) begin
            state_nxt = IDLE_LOW;
            level_nxt = 1'b0;
          end else begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (sync_in) begin
          state_nxt  = IDLE_HIGH;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE_LOW;
    endcase

    glitch_nxt = glitch_count;
    if (glitch_inc && (glitch_count != GLITCH_MAX)) begin
      glitch_nxt = glitch_count + GLITCH_W'(1);
    end
  end

endmodule
